// File: rtl/pwm_capture.sv
// PWM capture: measures high time, period and integer duty percent of an asynchronous input.
// Static-input detection reports a timeout result carrying the held level.
module pwm_capture #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic [6:0]       duty_percent_o,
  output logic             static_o,
  output logic             static_level_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int NW = CNT_W + 7;
  localparam int SW = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]    LAST_STEP = SW'(NW - 1);

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  state_t state, state_next;

  logic sync1, sync2, sync3, rise, fall, edge_seen;
  logic [CNT_W-1:0] period_cnt, high_cnt, to_cnt;
  logic armed, restart, close, fire, start, ov_set, finish;

  logic [CNT_W-1:0] den, rem, op_high;
  logic [NW-1:0]    quo, q_next;
  logic [SW-1:0]    step;
  logic [CNT_W:0]   rem_sh, diff;
  logic [CNT_W-1:0] rem_next;
  logic             ge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // sync3 is the level aligned with the rise/fall flags; all counting uses it
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
      fall  <= ~sync2 & sync3;
    end
  end

  assign edge_seen = rise | fall;

  // Valid/ready-free interface: meas_valid_o is a single-cycle strobe, results hold until the next strobe.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    close      = 1'b0;
    fire       = armed && !edge_seen && (to_cnt >= TO_LIMIT) && !busy_o;
    case (state)
      IDLE: begin
        if (rise) begin
          restart    = 1'b1;
          state_next = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          restart = 1'b1;
          close   = 1'b1;
        end else if (fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign start  = close && !busy_o;
  assign ov_set = close && busy_o;
  assign finish = busy_o && (step == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (restart) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (state == MEAS) begin
      period_cnt <= sat_inc(period_cnt);
      if (sync3) high_cnt <= sat_inc(high_cnt);
    end
  end

  // One static report per quiet stretch: armed drops on report, any edge re-arms
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      armed  <= 1'b1;
    end else begin
      if (edge_seen) to_cnt <= '0;
      else           to_cnt <= sat_inc(to_cnt);
      if (edge_seen) armed <= 1'b1;
      else if (fire) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         overrun_o <= 1'b0;
    else if (ov_set) overrun_o <= 1'b1;
  end

  // Restoring divider step; the top bit of diff is the borrow since rem < den always holds
  always_comb begin
    rem_sh   = {rem, quo[NW-1]};
    diff     = rem_sh - {1'b0, den};
    ge       = ~diff[CNT_W];
    rem_next = ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    q_next   = {quo[NW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o  <= 1'b0;
      step    <= '0;
      rem     <= '0;
      quo     <= '0;
      den     <= '0;
      op_high <= '0;
    end else if (busy_o) begin
      rem  <= rem_next;
      quo  <= q_next;
      step <= step + 1'b1;
      if (finish) busy_o <= 1'b0;
    end else if (start) begin
      den     <= period_cnt;
      op_high <= high_cnt;
      quo     <= {7'b0, high_cnt} * NW'(100);
      rem     <= '0;
      step    <= '0;
      busy_o  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid_o   <= 1'b0;
      high_cnt_o     <= '0;
      period_cnt_o   <= '0;
      duty_percent_o <= '0;
      static_o       <= 1'b0;
      static_level_o <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      if (finish) begin
        meas_valid_o   <= 1'b1;
        high_cnt_o     <= op_high;
        period_cnt_o   <= den;
        duty_percent_o <= (q_next > NW'(100)) ? 7'd100 : q_next[6:0];
        static_o       <= 1'b0;
      end else if (fire) begin
        meas_valid_o   <= 1'b1;
        high_cnt_o     <= '0;
        period_cnt_o   <= '0;
        duty_percent_o <= sync3 ? 7'd100 : 7'd0;
        static_o       <= 1'b1;
        static_level_o <= sync3;
      end
    end
  end

endmodule
